// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Definitions shared by the data-memory responder and the planned
//   instruction-memory responder: word/byte-enable widths, the responder
//   FSM state type and the address legality check.
package riscv_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // An access is illegal when it is not word aligned or lies beyond the
  // last byte of the array (limit = DEPTH*4).
  function automatic logic addr_is_bad(input logic [31:0] addr,
                                       input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// dmem_sram_array
//   Single-port synchronous word array with per-byte-lane write enables and
//   a registered read port. Each lane is held in its own 8-bit array so a
//   lane write never touches the other lanes' storage.
// Ports:
//   i_clk    clock
//   i_en     access strobe (one read or write this edge)
//   i_we     1 = write enabled lanes, 0 = read word into o_rdata
//   i_be     byte-lane write enables, bit i = bits 8i+7:8i
//   i_addr   word index
//   i_wdata  write data, lane aligned
//   o_rdata  read data, updated only on a read access, held otherwise
module dmem_sram_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [BE_W-1:0]           i_be,
  input  logic [$clog2(DEPTH)-1:0]  i_addr,
  input  logic [WORD_W-1:0]         i_wdata,
  output logic [WORD_W-1:0]         o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge i_clk) begin
        if (i_en) begin
          if (i_we) begin
            if (i_be[gi]) begin
              r_mem[i_addr] <= i_wdata[8*gi +: 8];
            end
          end else begin
            r_q <= r_mem[i_addr];
          end
        end
      end

      assign o_rdata[8*gi +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data port. Accepts one load/store
//   at a time, waits WAIT_CYCLES cycles, accesses the internal SRAM and
//   returns read data plus an error flag on a valid/ready response channel.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready      request handshake
//   i_req_addr, i_req_we,
//   i_req_be, i_req_wdata          request payload, sampled at acceptance
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_rdata, o_rsp_err         response payload, stable while valid
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [31:0]       i_req_addr,
  input  logic              i_req_we,
  input  logic [BE_W-1:0]   i_req_be,
  input  logic [WORD_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [WORD_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  mem_state_e        r_state, w_state_next;
  logic [7:0]        r_cnt, w_cnt_next;
  logic              r_req_ready;
  logic [31:0]       r_addr;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [WORD_W-1:0] r_wdata;
  logic              r_rsp_err;
  logic              r_rd_sel;     // response word comes from the SRAM read port
  logic              w_accept;
  logic              w_access;
  logic              w_err;
  logic [WORD_W-1:0] w_sram_rdata;

  assign w_accept = (r_state == IDLE) && r_req_ready && i_req_valid;
  assign w_access = (r_state == WAIT) && (r_cnt == 8'd0);
  assign w_err    = addr_is_bad(r_addr, ADDR_LIMIT);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = WAIT;
          w_cnt_next   = 8'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (r_cnt != 8'd0) begin
          w_cnt_next = r_cnt - 8'd1;
        end else begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_req_ready <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rsp_err   <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      // Registered so that ready stays low during reset and rises on the
      // same edge that completes the response handshake.
      r_req_ready <= (w_state_next == IDLE);
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_we    <= i_req_we;
        r_be    <= i_req_be;
        r_wdata <= i_req_wdata;
      end
      if (w_access) begin
        r_rsp_err <= w_err;
        r_rd_sel  <= !r_we && !w_err;
      end
    end
  end

  // Illegal accesses never reach the array, so a bad store changes nothing.
  dmem_sram_array #(
    .DEPTH (DEPTH)
  ) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_access && !w_err),
    .i_we    (r_we),
    .i_be    (r_be),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_sram_rdata)
  );

  // The SRAM read register only changes on a load access, which is also
  // the edge r_rd_sel is updated, so the response word is held stable.
  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rd_sel ? w_sram_rdata : '0;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
    .i_req_addr(a_req_addr), .i_req_we(a_req_we), .i_req_be(a_req_be),
    .i_req_wdata(a_req_wdata),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
    .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH_B), .WAIT_CYCLES(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
    .i_req_addr(b_req_addr), .i_req_we(b_req_we), .i_req_be(b_req_be),
    .i_req_wdata(b_req_wdata),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
    .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference memory: plain word array plus a "contents known" flag.
  logic [31:0] mdl_mem   [DEPTH];
  bit          mdl_known [DEPTH];

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic err, output bit known);
    int idx;
    err   = (addr % 4 != 0) || (addr >= DEPTH * 4);
    rdata = 32'h0;
    known = 1'b1;
    if (!err) begin
      idx = int'(addr / 4);
      if (we) begin
        if (be == 4'hF) begin
          mdl_mem[idx]   = wdata;
          mdl_known[idx] = 1'b1;
        end else if (mdl_known[idx]) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) mdl_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        rdata = mdl_mem[idx];
        known = mdl_known[idx];
      end
    end
  endtask

  // One full transaction on DUT A; rsp_ready held low for 'hold' cycles
  // after rsp_valid is seen. Checks latency, hold stability and handshake.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output logic err);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!a_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("a_req_ready_idle", a_req_ready, 1);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_be    = be;
    a_req_wdata = wdata;
    @(negedge clk);
    // Garbage on the request bus must be ignored after acceptance.
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom);
    a_req_addr  = $urandom;
    a_req_be    = 4'($urandom);
    a_req_wdata = $urandom;
    lat = 0;
    while (!a_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("a_latency", lat, WAIT_A + 1);
    rdata = a_rsp_rdata;
    err   = a_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("a_hold_valid", a_rsp_valid, 1);
      chk("a_hold_rdata", a_rsp_rdata, rdata);
      chk("a_hold_err", a_rsp_err, err);
      chk("a_hold_req_ready", a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("a_post_rsp_valid", a_rsp_valid, 0);
    chk("a_post_req_ready", a_req_ready, 1);
    $display("txn we=%0d addr=0x%08h be=%b wdata=0x%08h -> rdata=0x%08h err=%0d",
             we, addr, be, wdata, rdata, err);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    bit          mkn;
    int          guard, lat, last_acc, nacc;
    logic [31:0] addr;

    tbl[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,   4'h2, 32'h0000AB00, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADABEF, 1'b0};
    tbl[4]  = '{1'b1, 32'h10,   4'h0, 32'h12345678, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADABEF, 1'b0};
    tbl[6]  = '{1'b0, 32'h12,   4'h0, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h1000, 4'h0, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b1, 32'h0,    4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 32'h1000, 4'hF, 32'h0BADBAD0, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h0,    4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[11] = '{1'b1, 32'h11,   4'hF, 32'h99999999, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADABEF, 1'b0};
    tbl[13] = '{1'b1, 32'h20,   4'hF, 32'h11111111, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 32'h20,   4'h0, 32'h0,        32'h11111111, 1'b0};
    tbl[15] = '{1'b1, 32'hFFC,  4'hF, 32'hA5A55A5A, 32'h0,        1'b0};
    tbl[16] = '{1'b0, 32'hFFC,  4'h0, 32'h0,        32'hA5A55A5A, 1'b0};

    for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;

    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_be = 0; a_req_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_be = 0; b_req_wdata = 0; b_rsp_ready = 0;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_req_ready", a_req_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_a_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_a_rsp_err", a_rsp_err, 0);
    chk("rst_b_req_ready", b_req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_a_req_ready", a_req_ready, 1);
    chk("rel_a_rsp_valid", a_rsp_valid, 0);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      a_txn(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, 0, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
      model_access(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, mrd, mer, mkn);
    end

    // Response held 5 cycles while a second request waits.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0; a_req_wdata = 32'h0;
    @(negedge clk);
    a_req_we = 1'b1; a_req_addr = 32'h24; a_req_be = 4'hF; a_req_wdata = 32'h77777777;
    guard = 0;
    while (!a_rsp_valid && guard < 300) begin
      chk("hs_wait_req_ready", a_req_ready, 0);
      @(negedge clk);
      guard++;
    end
    chk("hs_rsp_valid", a_rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hs_hold_valid", a_rsp_valid, 1);
      chk("hs_hold_rdata", a_rsp_rdata, 32'hDEADABEF);
      chk("hs_hold_err", a_rsp_err, 0);
      chk("hs_hold_req_ready", a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("hs_after_rsp_valid", a_rsp_valid, 0);
    chk("hs_after_req_ready", a_req_ready, 1);
    @(negedge clk);
    chk("hs_second_accepted", a_req_ready, 0);
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("hs_second_latency", lat, WAIT_A + 1);
    chk("hs_second_err", a_rsp_err, 0);
    chk("hs_second_rdata", a_rsp_rdata, 0);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    model_access(1'b1, 32'h24, 4'hF, 32'h77777777, mrd, mer, mkn);
    $display("txn held-response load 0x10 then store 0x24 accepted after handshake");
    a_txn(1'b0, 32'h24, 4'h0, 32'h0, 0, rd, er);
    chk("hs_load24", rd, 32'h77777777);

    // Reset during WAIT of a store to 0x20.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20; a_req_be = 4'hF; a_req_wdata = 32'h5555AAAA;
    @(negedge clk);
    a_req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", a_rsp_valid, 0);
    chk("mid_rst_req_ready", a_req_ready, 0);
    chk("mid_rst_rsp_rdata", a_rsp_rdata, 0);
    chk("mid_rst_rsp_err", a_rsp_err, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_held_valid", a_rsp_valid, 0);
    rst_n = 1'b1;
    $display("txn store 0x20 aborted by reset");
    a_txn(1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er);
    chk("mid_rst_load20", rd, 32'h11111111);
    chk("mid_rst_load20_err", er, 0);

    // Randomised traffic against the reference model.
    for (int w = 0; w < 16; w++) begin
      a_txn(1'b1, 32'(w * 4), 4'hF, $urandom, 0, rd, er);
      model_access(1'b1, 32'(w * 4), 4'hF, a_req_wdata, mrd, mer, mkn);
    end
    // Initial pool writes above used random data; resync model by reading back
    // is not allowed, so rewrite the pool with known values.
    for (int w = 0; w < 16; w++) begin
      logic [31:0] v;
      v = $urandom;
      a_txn(1'b1, 32'(w * 4), 4'hF, v, 0, rd, er);
      model_access(1'b1, 32'(w * 4), 4'hF, v, mrd, mer, mkn);
    end
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      int          sel, hold;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      addr = 32'($urandom_range(0, 15) * 4);
      else if (sel == 7) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (sel == 8) addr = 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
      else               addr = 32'hFFC;
      we   = 1'($urandom);
      be   = 4'($urandom);
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      a_txn(we, addr, be, wd, hold, rd, er);
      model_access(we, addr, be, wd, mrd, mer, mkn);
      chk("rnd_err", er, mer);
      if (mkn) chk("rnd_rdata", rd, mrd);
    end

    // WAIT_CYCLES=0 instance: back-to-back requests with rsp_ready high.
    b_rsp_ready = 1'b1;
    last_acc = -100;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_be = 4'hF;
        b_req_addr = 32'h0; b_req_wdata = $urandom;
      end
      chk("b_rsp_valid", b_rsp_valid, (c == last_acc + 2) ? 32'd1 : 32'd0);
      if (b_rsp_valid) begin
        chk("b_rsp_err", b_rsp_err, 0);
        chk("b_rsp_rdata", b_rsp_rdata, 0);
        $display("txn B store response at cycle %0d", c);
      end
      if (b_req_ready) begin
        if (nacc > 0) chk("b_spacing", c - last_acc, 3);
        last_acc = c;
        nacc++;
      end else if (c == last_acc + 1) begin
        b_req_addr  = 32'((nacc % DEPTH_B) * 4);
        b_req_wdata = $urandom;
      end
    end
    b_req_valid = 1'b0;
    chk("b_accept_count", nacc, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipelined core's data port: accepts one load/store request at a time over a valid/ready request channel, models a configurable number of wait states, performs the access on an internal word-organised SRAM with byte-enable writes, and returns read data plus an error flag over a valid/ready response channel. It sits outside the core, opposite the memory stage, and replaces the zero-latency combinational data memory when wait-state behaviour must be exercised.

## Interface
- DEPTH, 1024: number of 32-bit words; byte address range 0 .. DEPTH*4-1.
- WAIT_CYCLES, 2: wait states between acceptance and the memory access; 0..255 legal.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_be  in  4  byte enables for stores, bit i = byte lane i (bits 8i+7:8i).
- req_wdata  in  32  store data, lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  full aligned word for loads; 0 for stores and errors.
- rsp_err  out  1  address out of range or misaligned.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr/we/be/wdata, load wait counter with WAIT_CYCLES, go WAIT.
- WAIT: req_ready=0. If counter≠0, decrement. If counter==0, perform access, register rsp_rdata/rsp_err, go RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready; then go IDLE.
- Error check (done at access): err=1 if addr[1:0]≠0 or addr ≥ DEPTH*4. On error: no array write, rsp_rdata=0.
- Store: only lanes with be bit set are written; be=0000 is a legal no-op, err=0. rsp_rdata=0.
- Load: rsp_rdata = word at addr[log2(DEPTH)+1:2]; req_be ignored. Byte/half extraction is the core's job.
- Only one transaction outstanding; no request is accepted while in WAIT or RESP.
- Array contents are not reset; only FSM, counter and outputs are.

## Timing
- Reset values: req_ready=0 while rst=0, 1 in IDLE after release; rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Acceptance edge E0. Access and response registration on edge E0+WAIT_CYCLES+1; rsp_valid high from that edge onward. WAIT_CYCLES=0 → rsp_valid one cycle after acceptance.
- rsp_ready low: response held indefinitely, rsp_rdata/rsp_err unchanged.
- Response handshake edge: rsp_valid falls and req_ready rises on the same edge; next request is accepted no earlier than the following edge. Minimum spacing between acceptances: WAIT_CYCLES+3 cycles.
- rsp_ready high before rsp_valid has no effect.
- req_* inputs are sampled only at acceptance; changes during WAIT/RESP are ignored.
- Reset asserted mid-transaction: FSM to IDLE immediately, response dropped; a store is not committed unless its access edge already occurred.
- Counter width 8 bits; no wrap since it only decrements from WAIT_CYCLES to 0.

## Structure
- Shared package riscv_mem_pkg: FSM state enum (IDLE/WAIT/RESP), WORD_W=32, BE_W=4 constants; reused by future instruction-memory responder.
- Sub-module dmem_sram_array: single-port synchronous word array, DEPTH parameter, 4-lane byte write enable, registered read data. Responder owns FSM, counter, range check and response registers.

## Test plan
- Reset then store addr=0x10, be=1111, wdata=0xDEADBEEF, WAIT_CYCLES=2 → rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0; load addr=0x10 → rsp_rdata=0xDEADBEEF.
- Partial store be=0010, wdata=0x0000AB00 over 0xDEADBEEF → load returns 0xDEADABEF; be=0000 store → word unchanged, err=0.
- Load addr=0x12 and load addr=DEPTH*4 → rsp_err=1, rsp_rdata=0; store to DEPTH*4 → no array change (verify neighbouring word 0 unchanged).
- rsp_ready held low 5 cycles in RESP → rsp_valid/rsp_rdata stable, req_ready=0, second req_valid not accepted until cycle after response handshake.
- WAIT_CYCLES=0 build: back-to-back requests with rsp_ready=1 → accepts every 3 cycles, each response 1 cycle after acceptance.
- Assert rst during WAIT of a store to 0x20 (old value 0x11111111) → outputs return to reset values immediately, 0x20 still reads 0x11111111 after release.
